serial_tx: RTL and testbench
============================

# serial_tx

Framed serial transmitter for the team's single-wire links. It accepts a parallel word over a valid/ready handshake and drives it out LSB-first on one line. Each word is framed by a low start bit and a high stop bit, and every bit is held for a fixed number of clocks. It is the driving end of the link; the far end is a registered sampling receiver clocked in the same domain or a compatible one.

## Interface
- CLKS_PER_BIT, default 16: clocks each serial bit is held; legal range ≥ 2.
- DATA_BITS, default 8: payload width; legal range 5..9.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; clock clk.
- tx_data  in  DATA_BITS  word to send; sampled only on the accept edge.
- tx_valid  in  1  word on tx_data is offered.
- tx_ready  out  1  block can accept a word this cycle.
- tx  out  1  serial line; idles high.
- busy  out  1  frame in progress (start, data or stop).

## Operation
- All outputs are registered.
- Reset values (reset low at a rising edge): tx=1, tx_ready=1, busy=0, state=IDLE, all counters 0.
- Accept: a rising edge with tx_valid=1 and tx_ready=1 does the following.
  - Latches tx_data into the shift register.
  - Moves the state machine to START.
  - In the following cycle: tx=0, tx_ready=0, busy=1.
- tx_valid while tx_ready=0 is ignored; no queueing.
- tx_data changes after the accept edge have no effect on the frame in flight.
- States:
  - IDLE: tx=1. Goes to START on accept.
  - START: tx=0 for CLKS_PER_BIT cycles, then goes to DATA with bit_idx=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment bit_idx. After bit DATA_BITS-1, goes to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then goes to IDLE with tx_ready=1 and busy=0.
- Counters:
  - clk_cnt is $clog2(CLKS_PER_BIT) bits wide. It counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary, and is held at 0 in IDLE.
  - bit_idx is $clog2(DATA_BITS) bits wide and never exceeds DATA_BITS-1.
- Reset mid-frame: the frame is abandoned at that edge. tx=1 and tx_ready=1 the next cycle; no stop bit is emitted.
- tx_valid=1 held continuously: words are sent back-to-back. Exactly 1 idle-high cycle separates each stop bit from the next start bit, because acceptance occurs in the first IDLE cycle.

## Timing
- Accept edge to tx falling: 1 cycle.
- Frame length: tx low at start to tx_ready high = (DATA_BITS+2)*CLKS_PER_BIT cycles.
- Every bit is exactly CLKS_PER_BIT cycles, with no jitter or stretching.
- Sustained throughput: one word per (DATA_BITS+2)*CLKS_PER_BIT+1 cycles.
- tx_ready and busy are always complementary after reset.

## Structure
- Shared package serial_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - the idle line level constant (1'b1) and start level constant (1'b0);
  - the frame length function frame_cycles(CLKS_PER_BIT, DATA_BITS). The receiver side uses the same package.
- One sub-module, bit_timer: a CLKS_PER_BIT-parameterised counter with clear input and a bit_done pulse output. It is reused by the future receiver.
- The top level holds the FSM, shift register and bit_idx.

## Test plan
- Reset: hold reset low 3 cycles with tx_valid=1 -> tx=1, tx_ready=1, busy=0 throughout; no frame starts until reset is high.
- Single word (CLKS_PER_BIT=4, DATA_BITS=8), send 0xA5:
  - tx sequence, 4 cycles per bit: 0 | 1,0,1,0,0,1,0,1 | 1;
  - tx_ready returns after 40 cycles.
- Back-to-back: send 0x00 then 0xFF with tx_valid held high -> two frames separated by exactly 1 idle-high cycle; the second payload is all ones.
- Ignored input: pulse tx_valid with 0x3C mid-frame and change tx_data during DATA -> in-flight frame unchanged; 0x3C is never sent.
- Reset mid-frame: assert reset during data bit 3 of 0x5A -> tx=1 from the next cycle; the next accepted word 0x81 is framed correctly.
- Parameter corner: CLKS_PER_BIT=2, DATA_BITS=5, send 5'b10011 -> 14-cycle frame, bits 1,1,0,0,1 after start.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the single-wire serial link (transmitter and receiver).
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // Clocks from start-bit falling edge to the end of the stop bit.
  function automatic int unsigned frame_cycles(input int unsigned clks_per_bit,
                                               input int unsigned data_bits);
    return (data_bits + 2) * clks_per_bit;
  endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, pulses bit_done_o on the last clock.
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic bit_done_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] clk_cnt_q;

  assign bit_done_o = !clear_i && (clk_cnt_q == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!reset || clear_i) begin
      clk_cnt_q <= '0;
    end else if (bit_done_o) begin
      clk_cnt_q <= '0;
    end else begin
      clk_cnt_q <= clk_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Framed LSB-first serial transmitter: start bit, DATA_BITS payload, stop bit, fixed bit period.
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int IW = $clog2(DATA_BITS);

  state_e               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [IW-1:0]        bit_idx_q;
  logic                 tx_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 bit_done;

  // Timer is held at zero while idle so the start bit gets a full period from the accept edge.
  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (state_q == IDLE),
    .bit_done_o(bit_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      tx_q      <= LINE_IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      bit_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tx_valid && ready_q) begin
            shift_q   <= tx_data;
            state_q   <= START;
            tx_q      <= LINE_START;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            bit_idx_q <= '0;
          end
        end
        START: begin
          if (bit_done) begin
            state_q   <= DATA;
            tx_q      <= shift_q[0];
            bit_idx_q <= '0;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx_q == IW'(DATA_BITS - 1)) begin
              state_q <= STOP;
              tx_q    <= LINE_IDLE;
            end else begin
              // tx is registered, so the next bit is taken from shift_q[1] before the shift lands.
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (bit_done) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= LINE_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one DUT at 4 clk/bit x 8 bits, one at 2 clk/bit x 5 bits.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d0;
  logic       v0;
  logic       r0, t0, b0;
  logic [4:0] d1;
  logic       v1;
  logic       r1, t1, b1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) u_dut0 (
    .clk(clk), .reset(reset), .tx_data(d0), .tx_valid(v0),
    .tx_ready(r0), .tx(t0), .busy(b0)
  );

  serial_tx #(.CLKS_PER_BIT(2), .DATA_BITS(5)) u_dut1 (
    .clk(clk), .reset(reset), .tx_data(d1), .tx_valid(v1),
    .tx_ready(r1), .tx(t1), .busy(b1)
  );

  typedef struct {
    bit          sel;
    int          cpb;
    int          nb;
    logic [7:0]  data;
    logic [10:0] exp;    // line level per bit slot, slot 0 = start bit
    int          poke;   // frame cycle at which a stray word is offered (0 = none)
    logic [7:0]  pdata;
  } vec_t;

  vec_t vecs[3];

  function automatic logic [2:0] obs(input bit sel);
    return sel ? {t1, r1, b1} : {t0, r0, b0};
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: tx/ready/busy got %b expected %b", name, act, exp);
    end
  endtask

  task automatic set_valid(input bit sel, input logic v);
    if (sel) v1 = v;
    else     v0 = v;
  endtask

  task automatic set_data(input bit sel, input logic [7:0] d);
    if (sel) d1 = d[4:0];
    else     d0 = d;
  endtask

  // Called at a negedge just before the accept posedge; returns at the idle-cycle negedge.
  task automatic chk_frame(input bit sel, input int cpb, input int nb, input logic [10:0] exp,
                           input int poke, input logic [7:0] pdata, input bit keep,
                           input int abort);
    int n;
    n = (nb + 2) * cpb;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check($sformatf("dut%0d frame cycle %0d", sel, k), obs(sel), {exp[(k-1)/cpb], 2'b01});
      if (k == 1 && !keep) set_valid(sel, 1'b0);
      if (k == poke) begin
        set_valid(sel, 1'b1);
        set_data(sel, pdata);
      end
      if (k == poke + 1 && !keep) begin
        set_valid(sel, 1'b0);
        set_data(sel, ~pdata);
      end
      if (k == abort) begin
        reset = 1'b0;
        set_valid(sel, 1'b0);
        return;
      end
    end
    @(negedge clk);
    check($sformatf("dut%0d idle after frame", sel), obs(sel), 3'b110);
  endtask

  initial begin
    vecs[0] = '{sel: 1'b0, cpb: 4, nb: 8, data: 8'hA5, exp: 11'h34A, poke: 0,  pdata: 8'h00};
    vecs[1] = '{sel: 1'b0, cpb: 4, nb: 8, data: 8'hC3, exp: 11'h386, poke: 10, pdata: 8'h3C};
    vecs[2] = '{sel: 1'b1, cpb: 2, nb: 5, data: 8'h13, exp: 11'h066, poke: 0,  pdata: 8'h00};

    reset = 1'b0;
    v0 = 1'b1; d0 = 8'hA5;
    v1 = 1'b1; d1 = 5'h1F;

    // Reset held with valid asserted: line stays idle.
    repeat (3) begin
      @(negedge clk);
      check("reset hold dut0", obs(0), 3'b110);
      check("reset hold dut1", obs(1), 3'b110);
    end
    reset = 1'b1;
    v0 = 1'b0;
    v1 = 1'b0;
    @(negedge clk);
    check("post-reset idle dut0", obs(0), 3'b110);
    check("post-reset idle dut1", obs(1), 3'b110);

    for (int i = 0; i < 3; i++) begin
      set_data(vecs[i].sel, vecs[i].data);
      set_valid(vecs[i].sel, 1'b1);
      chk_frame(vecs[i].sel, vecs[i].cpb, vecs[i].nb, vecs[i].exp,
                vecs[i].poke, vecs[i].pdata, 1'b0, 0);
      @(negedge clk);
      check($sformatf("vec%0d stays idle", i), obs(vecs[i].sel), 3'b110);
    end

    // Back-to-back 0x00 then 0xFF with valid held high.
    set_data(0, 8'h00);
    set_valid(0, 1'b1);
    chk_frame(0, 4, 8, 11'h200, 1, 8'hFF, 1'b1, 0);
    chk_frame(0, 4, 8, 11'h3FE, 0, 8'h00, 1'b0, 0);
    @(negedge clk);
    check("b2b stays idle", obs(0), 3'b110);

    // Reset during data bit 3 of 0x5A, then 0x81 must frame normally.
    set_data(0, 8'h5A);
    set_valid(0, 1'b1);
    chk_frame(0, 4, 8, 11'h2B4, 0, 8'h00, 1'b0, 18);
    @(negedge clk);
    check("reset mid-frame dut0", obs(0), 3'b110);
    reset = 1'b1;
    @(negedge clk);
    check("after mid-frame reset dut0", obs(0), 3'b110);
    set_data(0, 8'h81);
    set_valid(0, 1'b1);
    chk_frame(0, 4, 8, 11'h302, 0, 8'h00, 1'b0, 0);
    @(negedge clk);
    check("final idle dut1", obs(1), 3'b110);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
